// File: rtl/load_value_predictor.sv
// Last-value load predictor: PC-indexed table answers value-prediction requests on a load miss.
// Optional VP_CONFIDENCE_EN macro adds 2-bit confidence gating; DATA_WIDTH macro sets value/PC width.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module load_value_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vp_en,
  input  logic                   recover_en,
  input  logic [`DATA_WIDTH-1:0] addr,
  input  logic                   d_cache_valid,
  input  logic [`DATA_WIDTH-1:0] d_cache_data,
  input  logic                   recovery_done,
  output logic [`DATA_WIDTH-1:0] out,
  output logic                   out_valid,
  output logic                   vp_lock,
  output logic                   done,
  output logic                   recover,
  output logic                   recovery_done_ack,
  output logic [`DATA_WIDTH-1:0] last_predicted_pc
);
  localparam int W       = `DATA_WIDTH;
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, TRAIN, RECOVER} state_t;
  state_t state, state_next;

  logic [ENTRIES-1:0] entry_valid;
  logic [TAG_W-1:0]   entry_tag   [ENTRIES];
  logic [W-1:0]       entry_value [ENTRIES];

  logic [W-1:0]          pc_q, pc_next, out_next, last_pc_next;
  logic                  out_valid_next, vp_lock_next, done_next, recover_next, ack_next;
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic                  hit, resp_match, wr_en;
  logic                  unused_bits;

  assign rd_idx      = addr[INDEX_BITS+1:2];
  assign rd_tag      = addr[W-1:INDEX_BITS+2];
  assign wr_idx      = pc_q[INDEX_BITS+1:2];
  assign wr_tag      = pc_q[W-1:INDEX_BITS+2];
  assign resp_match  = (d_cache_data == out);
  assign unused_bits = ^{addr[1:0], pc_q[1:0]};

`ifdef VP_CONFIDENCE_EN
  logic [1:0] entry_conf [ENTRIES];
  logic [1:0] conf_cur, conf_inc, conf_dec;
  logic       train_confirm;

  assign hit = entry_valid[rd_idx] && (entry_tag[rd_idx] == rd_tag) && (entry_conf[rd_idx] >= 2'd2);
  assign conf_cur = entry_conf[wr_idx];
  assign conf_inc = (conf_cur == 2'd3) ? 2'd3 : conf_cur + 2'd1;
  assign conf_dec = (conf_cur == 2'd0) ? 2'd0 : conf_cur - 2'd1;
  // A below-threshold entry that sees the same value again counts as a confirmation.
  assign train_confirm = entry_valid[wr_idx] && (entry_tag[wr_idx] == wr_tag) &&
                         (entry_value[wr_idx] == d_cache_data);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (state == TRAIN)  entry_conf[wr_idx] <= train_confirm ? conf_inc : 2'd1;
      else if (resp_match) entry_conf[wr_idx] <= conf_inc;
      else                 entry_conf[wr_idx] <= conf_dec;
    end
  end
`else
  assign hit = entry_valid[rd_idx] && (entry_tag[rd_idx] == rd_tag);
`endif

  always_comb begin
    state_next     = state;
    pc_next        = pc_q;
    last_pc_next   = last_predicted_pc;
    out_next       = out;
    out_valid_next = out_valid;
    vp_lock_next   = vp_lock;
    recover_next   = recover;
    done_next      = 1'b0;
    ack_next       = 1'b0;
    wr_en          = 1'b0;
    case (state)
      IDLE: if (vp_en) begin
        pc_next      = addr;
        last_pc_next = addr;
        if (hit) begin
          out_next       = entry_value[rd_idx];
          out_valid_next = 1'b1;
          vp_lock_next   = 1'b1;
          state_next     = WAIT_MEM;
        end else begin
          state_next = TRAIN;
        end
      end
      WAIT_MEM: if (d_cache_valid) begin
        wr_en          = 1'b1;
        out_valid_next = 1'b0;
        if (!resp_match && recover_en) begin
          recover_next = 1'b1;
          state_next   = RECOVER;
        end else begin
          done_next    = 1'b1;
          vp_lock_next = 1'b0;
          state_next   = IDLE;
        end
      end
      TRAIN: if (d_cache_valid) begin
        wr_en      = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      RECOVER: if (recovery_done) begin
        recover_next = 1'b0;
        vp_lock_next = 1'b0;
        ack_next     = 1'b1;
        done_next    = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      entry_valid       <= '0;
      pc_q              <= '0;
      last_predicted_pc <= '0;
      out               <= '0;
      out_valid         <= 1'b0;
      vp_lock           <= 1'b0;
      done              <= 1'b0;
      recover           <= 1'b0;
      recovery_done_ack <= 1'b0;
    end else begin
      state             <= state_next;
      pc_q              <= pc_next;
      last_predicted_pc <= last_pc_next;
      out               <= out_next;
      out_valid         <= out_valid_next;
      vp_lock           <= vp_lock_next;
      done              <= done_next;
      recover           <= recover_next;
      recovery_done_ack <= ack_next;
      if (wr_en && state == TRAIN) entry_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and value storage need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_value[wr_idx] <= d_cache_data;
      if (state == TRAIN) entry_tag[wr_idx] <= wr_tag;
    end
  end
endmodule

// File: tb/tb_load_value_predictor.sv
// Scoreboard bench for load_value_predictor: randomized requests checked against a per-index last-value model.
module tb_load_value_predictor;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        vp_en = 1'b0, recover_en = 1'b0, d_cache_valid = 1'b0, recovery_done = 1'b0;
  logic [31:0] addr = '0, d_cache_data = '0;
  logic [31:0] out, last_predicted_pc;
  logic        out_valid, vp_lock, done, recover, recovery_done_ack;

  always #5 clk = ~clk;

  load_value_predictor #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .vp_en(vp_en), .recover_en(recover_en), .addr(addr),
    .d_cache_valid(d_cache_valid), .d_cache_data(d_cache_data), .recovery_done(recovery_done),
    .out(out), .out_valid(out_valid), .vp_lock(vp_lock), .done(done), .recover(recover),
    .recovery_done_ack(recovery_done_ack), .last_predicted_pc(last_predicted_pc)
  );

  typedef enum int {EV_PRED, EV_RECOVER, EV_DONE} ev_kind_t;
  typedef struct { ev_kind_t kind; logic [31:0] data; logic [31:0] ack; logic [31:0] pc; } ev_t;
  ev_t sb[$];
  int vectors = 0, miscompares = 0;

  // Reference model: each table slot remembers the last PC trained there and its value.
  bit          m_valid [64];
  logic [31:0] m_pc    [64];
  logic [31:0] m_val   [64];
  int          m_conf  [64];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_ev(ev_kind_t k, logic [31:0] d, logic [31:0] a, logic [31:0] pc);
    ev_t e;
    e.kind = k; e.data = d; e.ack = a; e.pc = pc;
    sb.push_back(e);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i;
    bit h;
    i = int'(pc[7:2]);
    h = m_valid[i] && (m_pc[i][31:8] == pc[31:8]);
`ifdef VP_CONFIDENCE_EN
    h = h && (m_conf[i] >= 2);
`endif
    return h;
  endfunction

  task automatic pop_expect(input ev_kind_t k);
    ev_t e;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_event: got event kind %0d, expected none at %0t", int'(k), $time);
      return;
    end
    e = sb.pop_front();
    check("event_kind", 32'(int'(k)), 32'(int'(e.kind)));
    case (k)
      EV_PRED:    check("pred_out", out, e.data);
      EV_RECOVER: check("recover_out_valid", 32'(out_valid), 32'd0);
      default: begin
        check("done_ack", 32'(recovery_done_ack), e.ack);
        check("done_last_pc", last_predicted_pc, e.pc);
        check("done_out_valid", 32'(out_valid), 32'd0);
      end
    endcase
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic ov_prev, rc_prev;
    ov_prev = 1'b0; rc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("lock_invariant", 32'(vp_lock), 32'(out_valid | recover));
        check("ack_only_with_done", 32'(recovery_done_ack & ~done), 32'd0);
        if (done) pop_expect(EV_DONE);
        if (recover && !rc_prev) pop_expect(EV_RECOVER);
        if (out_valid && !ov_prev) pop_expect(EV_PRED);
      end
      ov_prev = out_valid;
      rc_prev = recover;
    end
  end

  task automatic wait_done();
    int n;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'd1);
  endtask

  task automatic do_req(input logic [31:0] pc, input bit rec_en, input bit make_match,
                        input logic [31:0] alt_data, input int lat, input bit poke, input int rlat);
    int i;
    bit hit, mis;
    logic [31:0] data;
    i = int'(pc[7:2]);
    hit = m_hit(pc);
    if (hit) push_ev(EV_PRED, m_val[i], 32'd0, pc);
    vp_en = 1'b1; addr = pc; recover_en = rec_en;
    @(negedge clk);
    vp_en = 1'b0;
    if (poke) begin
      vp_en = 1'b1; addr = $urandom;
      @(negedge clk);
      vp_en = 1'b0;
    end
    repeat (lat) @(negedge clk);
    data = (hit && make_match) ? m_val[i] : alt_data;
    mis = hit && (data != m_val[i]);
    if (!hit) begin
`ifdef VP_CONFIDENCE_EN
      if (m_valid[i] && m_pc[i][31:8] == pc[31:8] && m_val[i] == data)
        m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
      else
        m_conf[i] = 1;
`else
      m_conf[i] = 1;
`endif
      m_valid[i] = 1'b1; m_pc[i] = pc; m_val[i] = data;
      push_ev(EV_DONE, 32'd0, 32'd0, pc);
    end else if (!mis) begin
      if (m_conf[i] < 3) m_conf[i]++;
      push_ev(EV_DONE, 32'd0, 32'd0, pc);
    end else begin
      m_val[i] = data;
      if (m_conf[i] > 0) m_conf[i]--;
      if (rec_en) push_ev(EV_RECOVER, 32'd0, 32'd0, pc);
      else        push_ev(EV_DONE, 32'd0, 32'd0, pc);
    end
    d_cache_valid = 1'b1; d_cache_data = data;
    @(negedge clk);
    d_cache_valid = 1'b0;
    if (mis && rec_en) begin
      check("recover_latency", 32'(recover), 32'd1);
      repeat (rlat) @(negedge clk);
      check("recover_held", 32'(recover), 32'd1);
      push_ev(EV_DONE, 32'd0, 32'd1, pc);
      recovery_done = 1'b1;
      @(negedge clk);
      recovery_done = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_out"}, out, 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_vp_lock"}, 32'(vp_lock), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_recover"}, 32'(recover), 32'd0);
    check({tag, "_ack"}, 32'(recovery_done_ack), 32'd0);
    check({tag, "_last_pc"}, last_predicted_pc, 32'd0);
  endtask

  // Issue a request, then assert reset asynchronously while it is in flight.
  task automatic reset_mid(input logic [31:0] pc);
    if (m_hit(pc)) push_ev(EV_PRED, m_val[int'(pc[7:2])], 32'd0, pc);
    vp_en = 1'b1; addr = pc;
    @(negedge clk);
    vp_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_outputs_clear("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h400; pcs[1] = 32'h500; pcs[2] = 32'h404;
    pcs[3] = 32'h1404; pcs[4] = 32'h8000_0010; pcs[5] = 32'h7f0;
    for (int k = 0; k < 64; k++) begin m_valid[k] = 1'b0; m_conf[k] = 0; end

    #1 rst_n = 1'b0;
    #1 check_outputs_clear("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(32'h400, 1'b0, 1'b1, 32'h1234, 1, 1'b0, 0);   // cold miss
    do_req(32'h400, 1'b0, 1'b1, 32'h0,    1, 1'b0, 0);   // hit, confirmed
    do_req(32'h400, 1'b1, 1'b0, 32'h5678, 1, 1'b0, 3);   // mispredict with recovery
    do_req(32'h400, 1'b0, 1'b1, 32'h0,    0, 1'b0, 0);   // now predicts 0x5678
    do_req(32'h400, 1'b0, 1'b0, 32'h9abc, 1, 1'b0, 0);   // mispredict without recovery
    do_req(32'h500, 1'b0, 1'b1, 32'hbeef, 1, 1'b1, 0);   // alias miss, vp_en poked in TRAIN
    do_req(32'h400, 1'b0, 1'b1, 32'h1234, 0, 1'b0, 0);
    do_req(32'h400, 1'b0, 1'b1, 32'h0,    0, 1'b1, 0);
    reset_mid(32'h400);
    do_req(32'h400, 1'b0, 1'b1, 32'h1234, 0, 1'b0, 0);   // misses after reset
    do_req(32'h400, 1'b0, 1'b1, 32'h1234, 0, 1'b0, 0);
    do_req(32'h400, 1'b0, 1'b1, 32'h1234, 0, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        d_cache_valid = 1'b1; d_cache_data = $urandom;   // stray response in IDLE
        @(negedge clk);
        d_cache_valid = 1'b0;
        @(negedge clk);
      end
      if ($urandom_range(0, 39) == 0) reset_mid(pcs[$urandom_range(0, 5)]);
      else do_req(pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
